qspi_host_txn: RTL and testbench

//  QSPI initiator: the host end of the bridge's QSPI link. Takes one request (cmd, addr, dir,

---
 rtl/qspi_host_txn.sv | 169 ++++++++++++++++
 tb/tb_qspi_host_txn.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_host_txn.sv
// QSPI host: one request -> one mode-0 frame (CMD, quad ADDR, quad WAIT on reads, quad DATA).
// Define QSPI_HOST_CMD_QUAD_EN to send the command byte as two nibbles on IO[3:0].
module qspi_host_txn #(
  parameter int SPICMDBITS    = 8,
  parameter int SPIADDRBITS   = 32,
  parameter int SPIDATABITS   = 32,
  parameter int SPIWAITCYCLES = 8,
  parameter int CEHIGHCYC     = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [7:0]             req_cmd_i,
  input  logic [SPIADDRBITS-1:0] req_addr_i,
  input  logic [SPIDATABITS-1:0] req_wdata_i,
  output logic                   resp_valid_o,
  output logic [SPIDATABITS-1:0] resp_rdata_o,
  output logic                   busy_o,
  output logic                   sck_o,
  output logic                   ce_no,
  output logic [3:0]             io_o,
  output logic [3:0]             io_oe_o,
  input  logic [3:0]             io_i
);
`ifdef QSPI_HOST_CMD_QUAD_EN
  localparam int CMDN = SPICMDBITS / 4;
  localparam bit CMDQ = 1'b1;
`else
  localparam int CMDN = SPICMDBITS;
  localparam bit CMDQ = 1'b0;
`endif
  localparam int TXW   = SPICMDBITS + SPIADDRBITS + SPIDATABITS;
  localparam int AN    = SPIADDRBITS / 4;
  localparam int DN    = SPIDATABITS / 4;
  localparam int WN    = SPIWAITCYCLES;
  localparam int WLAST = (WN > 0) ? WN - 1 : 0;
  localparam int M1    = (CMDN > AN) ? CMDN : AN;
  localparam int M2    = (WN > DN) ? WN : DN;
  localparam int M3    = (M1 > M2) ? M1 : M2;
  localparam int MAXC  = (M3 > CEHIGHCYC) ? M3 : CEHIGHCYC;
  localparam int CW    = $clog2(MAXC + 1);

  if ((SPIADDRBITS % 4) != 0 || (SPIDATABITS % 4) != 0 || CEHIGHCYC < 1 || SPICMDBITS != 8)
  begin : g_param_err
    $error("qspi_host_txn: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_ADDR, S_WAIT, S_DATA, S_CEHI} state_t;

  state_t                 state_q, state_d;
  logic                   hi_q, hi_d;
  logic [CW-1:0]          cnt_q, cnt_d, last;
  logic                   we_q;
  logic [TXW-1:0]         tx_q;
  logic [SPIDATABITS-1:0] rx_q, resp_rdata_q;
  logic                   resp_valid_q;
  logic                   accept, shift, frame_end;

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;

  // Bits advance at the end of each SCK high half, so IO and OE only move while SCK is low.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    shift       = 1'b0;
    frame_end   = 1'b0;
    req_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    sck_o       = 1'b0;
    ce_no       = 1'b1;
    io_o        = 4'h0;
    io_oe_o     = 4'h0;
    case (state_q)
      S_CMD:   last = CW'(CMDN - 1);
      S_ADDR:  last = CW'(AN - 1);
      default: last = CW'(WLAST);
    endcase

    case (state_q)
      S_IDLE: if (req_valid_i) begin
        accept  = 1'b1;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_CMD;
        hi_d    = 1'b1;
        cnt_d   = '0;
      end
      S_CMD, S_ADDR, S_WAIT, S_DATA: begin
        hi_d = ~hi_q;
        if (hi_q) begin
          shift = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (state_q != S_DATA && cnt_q == last) begin
            cnt_d = '0;
            case (state_q)
              S_CMD:   state_d = S_ADDR;
              S_ADDR:  state_d = (we_q || WN == 0) ? S_DATA : S_WAIT;
              default: state_d = S_DATA;
            endcase
          end
        end else if (state_q == S_DATA && cnt_q == CW'(DN)) begin
          // trailing low half of the last data bit is over
          state_d   = S_CEHI;
          hi_d      = 1'b0;
          cnt_d     = '0;
          frame_end = 1'b1;
        end
      end
      S_CEHI: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CEHIGHCYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_q)
      S_SETUP, S_CMD: begin
        io_oe_o = CMDQ ? 4'hF : 4'h1;
        io_o    = CMDQ ? tx_q[TXW-1 -: 4] : {3'b000, tx_q[TXW-1]};
      end
      S_ADDR: begin
        io_oe_o = 4'hF;
        io_o    = tx_q[TXW-1 -: 4];
      end
      S_DATA: if (we_q) begin
        io_oe_o = 4'hF;
        io_o    = tx_q[TXW-1 -: 4];
      end
      default: ;
    endcase
    if (state_q inside {S_SETUP, S_CMD, S_ADDR, S_WAIT, S_DATA}) ce_no = 1'b0;
    if (state_q inside {S_CMD, S_ADDR, S_WAIT, S_DATA}) sck_o = hi_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      hi_q         <= 1'b0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= frame_end;
      if (accept) begin
        tx_q <= {req_cmd_i, req_addr_i, req_wdata_i};
        we_q <= req_we_i;
        rx_q <= '0;
      end
      if (shift) tx_q <= (state_q == S_CMD && !CMDQ) ? (tx_q << 1) : (tx_q << 4);
      if (shift && state_q == S_DATA && !we_q) rx_q <= (rx_q << 4) | SPIDATABITS'(io_i);
      if (frame_end) resp_rdata_q <= we_q ? '0 : rx_q;
    end
  end
endmodule

// File: tb/tb_qspi_host_txn.sv
// Directed bench for qspi_host_txn: frame capture, IO target model and response scoreboard.
module tb_qspi_host_txn;
`ifdef QSPI_HOST_CMD_QUAD_EN
  localparam int CMDSCK = 2;
  localparam logic [7:0] RDCMD = 8'h9F;
`else
  localparam int CMDSCK = 8;
  localparam logic [7:0] RDCMD = 8'hEB;
`endif
  localparam int CEH = 2;

  typedef struct {
    logic [31:0] rd;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk_i = 1'b0, reset_ni = 1'b0;
  logic        req_valid = 1'b0, req_valid0 = 1'b0, req_we = 1'b0;
  logic [7:0]  req_cmd = 8'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready_o, resp_valid_o, busy_o, sck_o, ce_no;
  logic [31:0] resp_rdata_o;
  logic [3:0]  io_o, io_oe_o, io_i;
  logic        req_ready0, resp_valid0, busy0, sck0, ce_n0;
  logic [31:0] resp_rdata0;
  logic [3:0]  io0_o, io_oe0, io0_i;

  logic [31:0] rd_word = 32'hA5A50F0F, rd_word0 = 32'h3C96E187;
  int rise_n = 0, rise_n0 = 0;
  int n_cmp = 0, n_err = 0, cyc = 0, acc_n = 0, last_acc = 0, last_rise = 0;
  logic prev_ce = 1'b1;
  logic [3:0] cap_io[$], cap_oe[$];
  exp_t sb[$], sb0[$];
  logic [31:0] exp_rd;
  int exp_lat;

  always #5 clk_i = ~clk_i;

  qspi_host_txn #(.SPICMDBITS(8), .SPIADDRBITS(32), .SPIDATABITS(32), .SPIWAITCYCLES(8),
                  .CEHIGHCYC(CEH)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_we_i(req_we), .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .busy_o(busy_o),
    .sck_o(sck_o), .ce_no(ce_no), .io_o(io_o), .io_oe_o(io_oe_o), .io_i(io_i));

  qspi_host_txn #(.SPICMDBITS(8), .SPIADDRBITS(32), .SPIDATABITS(32), .SPIWAITCYCLES(0),
                  .CEHIGHCYC(CEH)) dut0 (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .req_we_i(req_we), .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid0), .resp_rdata_o(resp_rdata0), .busy_o(busy0),
    .sck_o(sck0), .ce_no(ce_n0), .io_o(io0_o), .io_oe_o(io_oe0), .io_i(io0_i));

  // Target model: counts SCK rises per frame and presents read nibbles after the wait phase.
  function automatic logic [3:0] nib(input logic [31:0] w, input int idx);
    if (idx < 0 || idx > 7) return 4'h0;
    return w[31-4*idx -: 4];
  endfunction

  always @(posedge sck_o or posedge ce_no)
    if (ce_no) rise_n <= 0; else rise_n <= rise_n + 1;
  always @(posedge sck0 or posedge ce_n0)
    if (ce_n0) rise_n0 <= 0; else rise_n0 <= rise_n0 + 1;

  assign io_i  = nib(rd_word,  rise_n  - (CMDSCK + 16) - 1);
  assign io0_i = nib(rd_word0, rise_n0 - (CMDSCK + 8) - 1);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: note an accept for the coming edge, then sample everything at the falling edge.
  task automatic tick();
    exp_t e;
    if (req_valid && req_ready_o) begin
      sb.push_back('{exp_rd, cyc + 1, exp_lat});
      acc_n++;
      last_acc = cyc + 1;
    end
    if (req_valid0 && req_ready0) sb0.push_back('{rd_word0, cyc + 1, 1 + 2*(CMDSCK + 16)});
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (sck_o) begin
      cap_io.push_back(io_o);
      cap_oe.push_back(io_oe_o);
    end
    if (ce_no && !prev_ce) last_rise = cyc;
    prev_ce = ce_no;
    if (resp_valid_o) begin
      if (sb.size() == 0) chk("spurious_resp", resp_valid_o, 1'b0);
      else begin
        e = sb.pop_front();
        chk("rdata", resp_rdata_o, e.rd);
        chk("latency", cyc - e.acc, e.lat);
        chk("ce_high_at_resp", ce_no, 1'b1);
      end
    end
    if (resp_valid0) begin
      if (sb0.size() == 0) chk("spurious_resp0", resp_valid0, 1'b0);
      else begin
        e = sb0.pop_front();
        chk("rdata_w0", resp_rdata0, e.rd);
        chk("latency_w0", cyc - e.acc, e.lat);
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && (sb.size() != 0 || sb0.size() != 0 || busy_o || busy0); k++) tick();
    chk("idle_timeout", {sb.size() == 0, sb0.size() == 0, busy_o, busy0}, 4'b1100);
  endtask

  task automatic do_req(input logic we, input logic [7:0] cmd, input logic [31:0] addr,
                        input logic [31:0] wd);
    req_we = we; req_cmd = cmd; req_addr = addr; req_wdata = wd;
    exp_rd  = we ? 32'h0 : rd_word;
    exp_lat = 1 + 2*(CMDSCK + 8 + (we ? 0 : 8) + 8);
    cap_io.delete(); cap_oe.delete();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_cmd = ~cmd; req_addr = ~addr; req_wdata = ~wd; req_we = ~we;
    wait_idle();
  endtask

  task automatic check_frame(input logic we, input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] wd);
    logic [7:0] c = 8'h0;
    logic [31:0] a = 32'h0, d = 32'h0;
    logic [3:0] v, oe;
    logic ok = 1'b1;
    int n = CMDSCK + 8 + (we ? 0 : 8) + 8;
    chk("sck_count", cap_io.size(), n);
    if (cap_io.size() == n) begin
      for (int i = 0; i < n; i++) begin
        v = cap_io[i]; oe = cap_oe[i];
        if (i < CMDSCK) begin
          if (CMDSCK == 8) begin
            c = {c[6:0], v[0]};
            if (oe != 4'h1 || v[3:1] != 3'b000) ok = 1'b0;
          end else begin
            c = {c[3:0], v};
            if (oe != 4'hF) ok = 1'b0;
          end
        end else if (i < CMDSCK + 8) begin
          a = {a[27:0], v};
          if (oe != 4'hF) ok = 1'b0;
        end else if (we) begin
          d = {d[27:0], v};
          if (oe != 4'hF) ok = 1'b0;
        end else if (oe != 4'h0 || v != 4'h0) ok = 1'b0;
      end
      chk("cmd_bits", c, cmd);
      chk("addr_nibbles", a, addr);
      if (we) chk("wdata_nibbles", d, wd);
      chk("oe_io_pattern", ok, 1'b1);
    end
  endtask

  initial begin
    int rdy_n, base;
    #12;
    chk("rst_ce_no", ce_no, 1'b1);
    chk("rst_sck", sck_o, 1'b0);
    chk("rst_io", io_o, 4'h0);
    chk("rst_oe", io_oe_o, 4'h0);
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    #2 reset_ni = 1'b1;

    do_req(1'b1, 8'h02, 32'h00001234, 32'hDEADBEEF);
    check_frame(1'b1, 8'h02, 32'h00001234, 32'hDEADBEEF);

    do_req(1'b0, RDCMD, 32'h0, 32'h0);
    check_frame(1'b0, RDCMD, 32'h0, 32'h0);
    chk("rdata_hold", resp_rdata_o, 32'hA5A50F0F);

    req_we = 1'b0; req_cmd = RDCMD; req_addr = 32'h40; req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    wait_idle();

    // Back-to-back: valid held high across two writes.
    req_we = 1'b1; req_cmd = 8'h32; req_addr = 32'h0000BEEF; req_wdata = 32'h12345678;
    exp_rd = 32'h0; exp_lat = 1 + 2*(CMDSCK + 16);
    base = acc_n; rdy_n = 0;
    req_valid = 1'b1;
    for (int k = 0; k < 300 && acc_n < base + 2; k++) begin
      tick();
      if (req_ready_o) rdy_n++;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc_n - base, 2);
    chk("b2b_gap", last_acc - last_rise, CEH + 1);
    chk("b2b_ready_cycles", rdy_n, 1);
    wait_idle();

    // Asynchronous reset in the middle of the address phase.
    req_we = 1'b1; req_cmd = 8'h02; req_addr = 32'hCAFEF00D; req_wdata = 32'h0;
    exp_rd = 32'h0; exp_lat = 1 + 2*(CMDSCK + 16);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (CMDSCK*2 + 5) tick();
    chk("mid_addr_oe", io_oe_o, 4'hF);
    chk("mid_addr_ce", ce_no, 1'b0);
    #2 reset_ni = 1'b0;
    sb.delete();
    #1;
    chk("arst_ce_no", ce_no, 1'b1);
    chk("arst_oe", io_oe_o, 4'h0);
    chk("arst_sck", sck_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    repeat (3) tick();
    chk("arst_no_resp", resp_valid_o, 1'b0);
    #2 reset_ni = 1'b1;
    do_req(1'b0, RDCMD, 32'h00000100, 32'h0);
    check_frame(1'b0, RDCMD, 32'h00000100, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
